// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    // Sequential fetch advances by one 32-bit instruction.
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    // IDLE: post-reset bubble, REQ: request outstanding, HOLD: slot full,
    // DROP: outstanding request made stale by a redirect, ERR: memory timeout.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        HOLD = 3'd2,
        DROP = 3'd3,
        ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_wdog.sv
// Watchdog counter: counts unacknowledged request cycles and reports when the
// count has reached the limit.
module fetch_wdog #(
    parameter int TIMEOUT = 16,
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] count;

    // Clear has priority over counting; the FSM leaves REQ/DROP at the limit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == limit);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a
// time, applies redirects, drops stale responses and holds the fetched
// instruction until decode consumes it.
//
// Handshake: imem_req/imem_addr_F stay asserted and stable until the cycle in
// which imem_ack=1; imem_rdata is taken in that same cycle. Toward decode,
// instr_valid_D/instr_D/pc_D hold until a cycle with stall_D=0 (consumed)
// or PCSrc_F=1 (flushed).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [ADDR_W-1:0]  PCBranch_F,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr_F,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [ADDR_W-1:0]  pc_D,
    input  logic               stall_D,
    output logic               imem_err
);

    localparam int WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic              in_flight;
    logic              wdog_clear;
    logic              wdog_enable;
    logic              wdog_expired;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .limit   (WDOG_LIMIT),
        .expired (wdog_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; an ack always wins over the watchdog, the watchdog
    // wins over a redirect of a still-unacknowledged request.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_ack)          state_next = PCSrc_F ? REQ : HOLD;
                else if (wdog_expired) state_next = ERR;
                else if (PCSrc_F)      state_next = DROP;
            end
            HOLD: begin
                if (PCSrc_F || !stall_D) state_next = REQ;
            end
            DROP: begin
                if (imem_ack)          state_next = REQ;
                else if (wdog_expired) state_next = ERR;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and watchdog controls decoded from state and registers only.
    always_comb begin
        in_flight   = (state == REQ) || (state == DROP);
        imem_req    = in_flight;
        imem_addr_F = req_addr;
        imem_err    = (state == ERR);
        wdog_enable = in_flight && !imem_ack;
        wdog_clear  = !in_flight || imem_ack || ((state == REQ) && (state_next == DROP));
    end

    // PC, request address and decode slot; redirects override sequential
    // increment and capture, nothing changes on the way into ERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            instr_valid_D <= 1'b0;
            instr_D       <= '0;
            pc_D          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PCSrc_F) pc <= PCBranch_F;
                    req_addr <= PCSrc_F ? PCBranch_F : pc;
                end
                REQ: begin
                    if (imem_ack) begin
                        if (PCSrc_F) begin
                            pc       <= PCBranch_F;
                            req_addr <= PCBranch_F;
                        end else begin
                            instr_D       <= imem_rdata;
                            pc_D          <= req_addr;
                            instr_valid_D <= 1'b1;
                            pc            <= req_addr + PC_STEP;
                        end
                    end else if (!wdog_expired && PCSrc_F) begin
                        pc <= PCBranch_F;
                    end
                end
                HOLD: begin
                    if (PCSrc_F) begin
                        instr_valid_D <= 1'b0;
                        pc            <= PCBranch_F;
                        req_addr      <= PCBranch_F;
                    end else if (!stall_D) begin
                        instr_valid_D <= 1'b0;
                        req_addr      <= pc;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        if (PCSrc_F) pc <= PCBranch_F;
                        req_addr <= PCSrc_F ? PCBranch_F : pc;
                    end else if (!wdog_expired && PCSrc_F) begin
                        pc <= PCBranch_F;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the PC/branch logic and a variable-latency instruction memory. Owns the program counter and issues one instruction-memory request at a time under a req/ack handshake. Applies branch redirects (PCSrc_F/PCBranch_F), drops in-flight responses made stale by a redirect, and holds fetched instructions while decode stalls. A watchdog flags a memory that never acknowledges.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT, 16, cycles a request may stay unacknowledged before error; 2..65535.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk.
- PCSrc_F  in  1  redirect pulse; when 1, the next PC is PCBranch_F.
- PCBranch_F  in  64  redirect target, valid when PCSrc_F=1.
- imem_req  out  1  request to instruction memory.
- imem_addr_F  out  64  request address, stable while imem_req=1.
- imem_ack  in  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr_valid_D  out  1  instr_D/pc_D hold an instruction for decode.
- instr_D  out  32  fetched instruction.
- pc_D  out  64  address of instr_D.
- stall_D  in  1  decode cannot accept; instruction consumed when instr_valid_D=1 and stall_D=0.
- imem_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, HOLD, DROP, ERR.
- Registers: pc (next fetch address), req_addr (address of outstanding request), output slot (instr_D, pc_D, instr_valid_D), wait counter.
- IDLE: imem_req=0. Always goes to REQ next cycle; req_addr<=pc.
- REQ: imem_req=1, imem_addr_F=req_addr.
  - imem_ack=1 and PCSrc_F=0: capture instr_D<=imem_rdata, pc_D<=req_addr, instr_valid_D<=1, pc<=req_addr+4, go to HOLD.
  - imem_ack=1 and PCSrc_F=1: discard the data, pc<=PCBranch_F, req_addr<=PCBranch_F, stay in REQ.
  - imem_ack=0 and PCSrc_F=1: pc<=PCBranch_F, go to DROP. req_addr is unchanged because the request must be held until acked.
- HOLD: imem_req=0.
  - stall_D=0: instruction consumed, instr_valid_D<=0, req_addr<=pc, go to REQ.
  - PCSrc_F=1 (any stall_D): flush, instr_valid_D<=0, pc<=PCBranch_F, req_addr<=PCBranch_F, go to REQ.
- DROP: imem_req=1, imem_addr_F=req_addr (stale address).
  - imem_ack=1: discard the data, req_addr<=pc, go to REQ.
  - A further PCSrc_F=1 in DROP overwrites pc only.
- ERR: imem_req=0, imem_err=1, all inputs ignored. Only reset exits.
- Redirect priority: PCSrc_F beats sequential increment and output capture in every state except ERR.
- PC arithmetic: 64-bit unsigned add, wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0. No alignment check; PCBranch_F is used verbatim.

## Timing
- Reset values: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, imem_req=0, imem_addr_F=RESET_PC, instr_valid_D=0, instr_D=0, pc_D=0, imem_err=0, wait counter=0.
- First request: imem_req=1 in the second cycle after reset deasserts.
- All outputs are registered or decoded from state/registers only. No combinational input-to-output path.
- Zero-wait memory (ack in the first REQ cycle): one instruction per 2 cycles (REQ, HOLD).
- Latency: ack at edge N gives instr_valid_D=1 from edge N onward.
- Watchdog: wait counter clears on entry to REQ/DROP and on ack. It increments each REQ/DROP cycle with imem_ack=0. At count TIMEOUT-1 with no ack, the next state is ERR.
- Reset mid-request: controller returns to IDLE and ignores any late ack. The memory must also be reset by the same reset.

## Structure
- fetch_ctrl_pkg: state enum fetch_state_t {IDLE, REQ, HOLD, DROP, ERR}, localparam PC_STEP=64'd4, instruction width 32, address width 64.
- One sub-module, fetch_wdog: counter with clear/enable/limit inputs and an expired output, parameterised by TIMEOUT.
- fetch_ctrl holds the FSM, pc/req_addr registers and the output slot.

## Test plan
- Reset then always-ack memory, stall_D=0, RESET_PC=0: pc_D sequence 0,4,8,12; instr_valid_D high every other cycle; imem_req first high 2 cycles after reset falls.
- Ack delayed 3 cycles with stall_D=0: imem_addr_F stays 0 for 3 cycles; instr_valid_D rises on the acking edge; next request addr 4.
- PCSrc_F=1, PCBranch_F=64'h1000 while in REQ with no ack, ack 2 cycles later: DROP holds the old addr; data never appears on instr_D; next request addr 64'h1000.
- PCSrc_F=1, PCBranch_F=64'h200 in HOLD with stall_D=1 and instr_valid_D=1: instr_valid_D=0 next cycle; next request addr 64'h200; the flushed instruction is never consumed.
- stall_D=1 for 5 cycles in HOLD: instr_D/pc_D stable and imem_req=0 throughout; REQ resumes the cycle after stall_D=0.
- TIMEOUT=16, memory never acks: imem_err=1 after 16 REQ cycles, imem_req=0, both held; reset clears both and restarts at RESET_PC.
